// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the unified instruction/data memory controller:
// access sizes, port identifiers and the response FSM state type.
package riscv_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DATA   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IFETCH = 2'd1,
        ST_DATA   = 2'd2
    } mem_state_t;

    // The unused size encoding 2'b11 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'b11) ? SZ_WORD : sz;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Store byte-enable/lane shifting and load lane extract/extend for the data port.
// Optional macro MISALIGN_CHK_EN flags misaligned half/word accesses instead of masking them.
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [1:0]  w_size;
    logic [1:0]  w_off;
    logic [4:0]  w_shift;
    logic [31:0] w_rshift;
    logic        w_mis;

    assign w_size = norm_size(i_size);

`ifdef MISALIGN_CHK_EN
    assign w_mis = ((w_size == SZ_HALF) && i_offset[0]) ||
                   ((w_size == SZ_WORD) && (i_offset != 2'b00));
    assign w_off = i_offset;
`else
    // Low address bits below the access alignment are simply dropped.
    assign w_mis = 1'b0;
    assign w_off = (w_size == SZ_WORD) ? 2'b00 :
                   (w_size == SZ_HALF) ? {i_offset[1], 1'b0} : i_offset;
`endif

    assign o_misalign = w_mis;
    assign w_shift    = {w_off, 3'b000};
    assign w_rshift   = i_rword >> w_shift;

    always_comb begin
        o_be    = 4'b0000;
        o_wword = 32'h0;
        o_rdata = 32'h0;
        case (w_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << w_off;
                o_wword = {24'h0, i_wdata[7:0]} << w_shift;
                o_rdata = {{24{~i_unsigned & w_rshift[7]}}, w_rshift[7:0]};
            end
            SZ_HALF: begin
                o_be    = 4'b0011 << w_off;
                o_wword = {16'h0, i_wdata[15:0]} << w_shift;
                o_rdata = {{16{~i_unsigned & w_rshift[15]}}, w_rshift[15:0]};
            end
            default: begin
                o_be    = 4'b1111;
                o_wword = i_wdata;
                o_rdata = i_rword;
            end
        endcase
        if (w_mis) begin
            o_be    = 4'b0000;
            o_rdata = 32'h0;
        end
    end

endmodule

// File: rtl/unified_mem_ctrl.sv
// Single-port memory shared by a fetch port and a data port: alternating arbiter,
// one-cycle response FSM and byte-lane array. Optional macro: MISALIGN_CHK_EN.
module unified_mem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_valid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
    output logic              d_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] r_mem [DEPTH_WORDS];
    mem_state_t  r_state;
    logic        r_last_grant;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;
    logic        r_d_err;

    logic          w_i_fire;
    logic          w_d_fire;
    logic [AW-1:0] w_i_idx;
    logic [AW-1:0] w_d_idx;
    logic [3:0]    w_be;
    logic [31:0]   w_wword;
    logic [31:0]   w_ld_data;
    logic          w_d_mis;
    logic          w_unused;

    assign w_i_idx = i_addr[AW+1:2];
    assign w_d_idx = d_addr[AW+1:2];

    mem_lane_align u_align (
        .i_size     (d_size),
        .i_unsigned (d_unsigned),
        .i_offset   (d_addr[1:0]),
        .i_wdata    (d_wdata),
        .i_rword    (r_mem[w_d_idx]),
        .o_be       (w_be),
        .o_wword    (w_wword),
        .o_rdata    (w_ld_data),
        .o_misalign (w_d_mis)
    );

    // Under contention the port that lost last time wins; reset blocks all grants.
    always_comb begin
        w_i_fire = 1'b0;
        w_d_fire = 1'b0;
        if (rst) begin
            if (i_req && d_req) begin
                w_i_fire = (r_last_grant == PORT_DATA);
                w_d_fire = (r_last_grant == PORT_IFETCH);
            end else begin
                w_i_fire = i_req;
                w_d_fire = d_req;
            end
        end
    end

    assign i_gnt = w_i_fire;
    assign d_gnt = w_d_fire;

    always_ff @(posedge clk) begin
        if (w_d_fire && d_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_d_idx][8*b +: 8] <= w_wword[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= PORT_DATA;
            r_i_rdata    <= 32'h0;
            r_d_rdata    <= 32'h0;
            r_d_err      <= 1'b0;
        end else begin
            r_i_rdata <= w_i_fire ? r_mem[w_i_idx] : 32'h0;
            r_d_rdata <= (w_d_fire && !d_we) ? w_ld_data : 32'h0;
            r_d_err   <= w_d_fire && w_d_mis;
            if (w_i_fire) begin
                r_state      <= ST_IFETCH;
                r_last_grant <= PORT_IFETCH;
            end else if (w_d_fire) begin
                r_state      <= ST_DATA;
                r_last_grant <= PORT_DATA;
            end else begin
                r_state <= ST_IDLE;
            end
        end
    end

    // Outputs are forced low while reset is held so a pending response never escapes.
    assign i_valid = rst && (r_state == ST_IFETCH);
    assign d_valid = rst && (r_state == ST_DATA);
    assign i_rdata = rst ? r_i_rdata : 32'h0;
    assign d_rdata = rst ? r_d_rdata : 32'h0;
`ifdef MISALIGN_CHK_EN
    assign d_err = rst && r_d_err;
`else
    assign d_err = 1'b0;
`endif

    assign w_unused = ^{i_addr, d_addr, r_d_err, w_d_mis};

endmodule
